// File: rtl/display_pkg.sv
// Shared constants, hex-to-segment table and output payload type
// for the multiplexed 7-segment display.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned HEX_W      = NUM_DIGITS * NIBBLE_W;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
  } disp_out_t;

  localparam disp_out_t DISP_BLANK = '{an: '1, seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/worm_scan_driver_if.sv
// Data inputs and display outputs of the worm scan driver.
interface worm_scan_driver_if;
  import display_pkg::*;

  logic [NUM_DIGITS-1:0] display_worm;
  logic [HEX_W-1:0]      hex_value;
  logic                  enable;
  logic [NUM_DIGITS-1:0] an;
  logic [SEG_W-1:0]      seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output display_worm, hex_value, enable,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  display_worm, hex_value, enable,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/worm_scan_driver.sv
// Multiplexed 6-digit hex display with the worm position on the decimal
// points; inputs are shadowed once per scan frame.
module worm_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned PRESC_W  = 10
) (
  input  logic                clkin,
  input  logic                reset,
  worm_scan_driver_if.slave   bus
);

  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic [NUM_DIGITS-1:0] shadow_worm_q, shadow_worm_d;
  logic [HEX_W-1:0]      shadow_hex_q, shadow_hex_d;
  logic                  frame_done_q, frame_done_d;
  logic                  tick_dly_q, tick_dly_d;
  logic                  enable_q, enable_d;
  disp_out_t             out_q, out_d;

  logic                  tick_c;
  logic [DIGIT_W-1:0]    slot_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic [SEG_W-1:0]      seg_dec_c;

  // Position within hex_value / display_worm, counted from the LSB end.
  assign slot_c   = LAST_DIGIT - digit_q;
  assign nibble_c = shadow_hex_q[{slot_c, 2'b00} +: NIBBLE_W];

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble_c),
    .seg_c  (seg_dec_c)
  );

  always_comb begin
    presc_d       = presc_q + PRESC_W'(1);
    digit_d       = digit_q;
    shadow_worm_d = shadow_worm_q;
    shadow_hex_d  = shadow_hex_q;
    frame_done_d  = 1'b0;
    tick_dly_d    = 1'b0;
    enable_d      = bus.enable;
    out_d         = out_q;

    tick_c = (presc_q == PRESC_W'(SCAN_DIV - 1));

    if (tick_c) begin
      presc_d    = '0;
      tick_dly_d = 1'b1;
      digit_d    = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIGIT_W'(1);
      if (digit_q == LAST_DIGIT) begin
        shadow_worm_d = bus.display_worm;
        shadow_hex_d  = bus.hex_value;
        frame_done_d  = 1'b1;
      end
    end

    // Refresh one cycle after a tick, or immediately on re-enable.
    if (!bus.enable) begin
      out_d = DISP_BLANK;
    end else if (tick_dly_q || !enable_q) begin
      out_d.an  = ~(NUM_DIGITS'(1) << digit_q);
      out_d.seg = seg_dec_c;
      out_d.dp  = ~shadow_worm_q[slot_c];
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      digit_q       <= LAST_DIGIT;
      shadow_worm_q <= '0;
      shadow_hex_q  <= '0;
      frame_done_q  <= 1'b0;
      tick_dly_q    <= 1'b0;
      enable_q      <= 1'b1;
      out_q         <= DISP_BLANK;
    end else begin
      presc_q       <= presc_d;
      digit_q       <= digit_d;
      shadow_worm_q <= shadow_worm_d;
      shadow_hex_q  <= shadow_hex_d;
      frame_done_q  <= frame_done_d;
      tick_dly_q    <= tick_dly_d;
      enable_q      <= enable_d;
      out_q         <= out_d;
    end
  end

  assign bus.an         = out_q.an;
  assign bus.seg        = out_q.seg;
  assign bus.dp         = out_q.dp;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/worm_scan_driver.md
Name: worm_scan_driver

Overview:
- Downstream consumer of the 6-bit one-hot worm pattern produced by the worm decoder.
- Drives a 6-digit multiplexed common-anode 7-segment display. Each digit shows one hex nibble of a 24-bit value. The worm position is shown as that digit's decimal point.
- Inputs are captured into shadow registers once per scan frame, so a frame never mixes old and new data.

Parameters:
- SCAN_DIV, 1000: clkin cycles per digit slot (scan tick period). Must be >= 2.
- PRESC_W, 10: prescaler width. Must satisfy 2^PRESC_W >= SCAN_DIV.

Ports:
- clkin  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- display_worm  in  6  one-hot worm position; bit 5 = leftmost digit (digit 0)
- hex_value  in  24  display value; [23:20] = digit 0 ... [3:0] = digit 5
- enable  in  1  1 = display on; 0 = all outputs blanked
- an  out  6  digit anodes, active-low; an[i] drives digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse when a new frame's shadow data is captured

Behaviour:
- Reset is asynchronous, active-high, clock is clkin. Reset values:
  - prescaler = 0, digit_idx = 5
  - shadow_worm = 0, shadow_hex = 0
  - an = 6'b111111, seg = 7'b1111111, dp = 1, frame_done = 0
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick = (prescaler == SCAN_DIV-1), asserted for one cycle every SCAN_DIV cycles.
  - Prescaler and scanning run regardless of enable.
- Digit index:
  - On tick: digit_idx <= (digit_idx == 5) ? 0 : digit_idx + 1.
  - No change otherwise.
- Frame capture:
  - On tick with digit_idx == 5: shadow_worm <= display_worm, shadow_hex <= hex_value.
  - The same edge sets frame_done = 1 (registered). frame_done returns to 0 on the next cycle.
  - Because reset sets digit_idx = 5, the first tick after reset captures inputs and starts at digit 0.
  - Inputs that change mid-frame have no effect until the next capture.
- Output stage:
  - Registered, fed from the post-tick digit_idx and shadow registers.
  - Outputs change exactly 1 clkin after the tick edge and hold until 1 cycle after the next tick.
  - enable = 1:
    - an = ~(6'b000001 << digit_idx)
    - seg = hexdecode(shadow_hex nibble for digit_idx)
    - dp = ~shadow_worm[5 - digit_idx]
  - enable = 0: an = 6'b111111, seg = 7'b1111111, dp = 1. Takes effect on the next clkin edge, not tick-aligned.
- Hex decode, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Non-one-hot worm input is not checked; dp is a plain per-bit mapping. All-zero means no dp lit; multiple bits mean multiple dps lit across the frame.
- Reset asserted mid-frame: immediate return to reset values. After release, the next capture occurs at the first tick.

Decomposition:
- Shared package `display_pkg`:
  - NUM_DIGITS = 6
  - SEG_BLANK = 7'b1111111
  - hex-to-segment constant table
- Sub-module `hex_to_7seg`: purely combinational 4-bit nibble to 7-bit active-low segments. Instantiated once on the selected nibble.

Test Plan (SCAN_DIV = 4):
- Reset then release, enable = 1, hex_value = 24'h012345, display_worm = 6'b100000 -> an/seg/dp stay at reset values for 3 cycles. frame_done pulses on the 4th edge. The 5th edge gives an = 111110, seg = 1000000, dp = 0.
- Same inputs, run 24 cycles -> an walks 111110, 111101, 111011, 110111, 101111, 011111 every 4 cycles. seg shows 0, 1, 2, 3, 4, 5. dp = 0 only on digit 0.
- Change display_worm to 6'b000100 while digit 2 is active -> no dp change in the current frame. Next frame after frame_done: dp = 0 only while an = 110111 (digit 3).
- hex_value = 24'hABCDEF, worm = 0 -> seg sequence 0001000, 0000011, 1000110, 0100001, 0000110, 0001110. dp = 1 throughout.
- Drop enable mid-slot -> next edge an = 111111, seg = 1111111, dp = 1. frame_done pulses continue every 24 cycles. Re-enable -> the current digit's pattern appears on the next edge.
- Assert reset while digit 3 is active -> all outputs return to reset values asynchronously, before the next clkin edge. After release, the first frame starts at digit 0 with freshly captured inputs.
